// File: rtl/regfile_fifo_ctrl.sv
// FIFO controller for a paired 32x4 register-file BEL; pop data 1 cycle (RD_REG=0) or 2 cycles (RD_REG=1) after pop_acc.
// Full blocks push unless popping, empty blocks pop; `REGFILE_FIFO_ERR_FLAGS_EN adds sticky ovf/udf flags.
module regfile_fifo_ctrl #(
    parameter int NoConfigBits = 2
) (
    input  logic                    UserCLK,
    input  logic                    Reset,
    input  logic                    push,
    input  logic [3:0]              push_data,
    input  logic                    pop,
    output logic [3:0]              pop_data,
    output logic                    pop_valid,
    output logic                    full,
    output logic                    empty,
    output logic [5:0]              count,
    output logic [3:0]              RF_D,
    output logic [4:0]              RF_W_ADR,
    output logic                    RF_W_EN,
    output logic [4:0]              RF_A_ADR,
    input  logic [3:0]              RF_AD,
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
    output logic                    ovf,
    output logic                    udf,
`endif
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic       rd_reg;
    logic       depth16;
    logic [5:0] depth;
    logic       push_acc;
    logic       pop_acc;
    logic       capture;

    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [5:0] count_q, count_d;
    logic       rd_stage_q, rd_stage_d;
    logic       pop_valid_q, pop_valid_d;
    logic [3:0] pop_data_q, pop_data_d;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
`endif

    // In 16-deep mode only the low nibble counts, so bit 4 never sets.
    function automatic logic [4:0] ptr_next(input logic [4:0] p, input logic d16);
        return d16 ? {1'b0, p[3:0] + 4'd1} : p + 5'd1;
    endfunction

    always_comb begin
        rd_reg   = ConfigBits[0];
        depth16  = ConfigBits[1];
        depth    = depth16 ? 6'd16 : 6'd32;
        full     = (count_q == depth);
        empty    = (count_q == 6'd0);
        push_acc = push & (~full | pop);
        pop_acc  = pop & ~empty;

        wr_ptr_d = push_acc ? ptr_next(wr_ptr_q, depth16) : wr_ptr_q;
        rd_ptr_d = pop_acc  ? ptr_next(rd_ptr_q, depth16) : rd_ptr_q;
        count_d  = count_q + {5'd0, push_acc} - {5'd0, pop_acc};

        // Registered port A delivers data one edge after the address is sampled.
        rd_stage_d  = pop_acc & rd_reg;
        capture     = rd_reg ? rd_stage_q : pop_acc;
        pop_valid_d = capture;
        pop_data_d  = capture ? RF_AD : pop_data_q;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
        ovf_d = ovf_q | (push & full & ~pop);
        udf_d = udf_q | (pop & empty);
`endif
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            wr_ptr_q    <= 5'd0;
            rd_ptr_q    <= 5'd0;
            count_q     <= 6'd0;
            rd_stage_q  <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= 4'd0;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_stage_q  <= rd_stage_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
`endif
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign RF_D      = push_data;
    assign RF_W_ADR  = wr_ptr_q;
    assign RF_A_ADR  = rd_ptr_q;
    assign RF_W_EN   = push_acc & ~Reset;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Bench for regfile_fifo_ctrl with a behavioural 32x4 register file and a pop-data scoreboard.
module tb_regfile_fifo_ctrl;

    logic       UserCLK = 1'b0;
    logic       Reset = 1'b1;
    logic       push = 1'b0;
    logic [3:0] push_data = 4'd0;
    logic       pop = 1'b0;
    logic [3:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic [3:0] RF_D;
    logic [4:0] RF_W_ADR;
    logic       RF_W_EN;
    logic [4:0] RF_A_ADR;
    logic [3:0] RF_AD;
    logic [1:0] cfg = 2'b00;
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
    logic       ovf;
    logic       udf;
`endif

    regfile_fifo_ctrl #(.NoConfigBits(2)) dut (
        .UserCLK   (UserCLK),
        .Reset     (Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .RF_D      (RF_D),
        .RF_W_ADR  (RF_W_ADR),
        .RF_W_EN   (RF_W_EN),
        .RF_A_ADR  (RF_A_ADR),
        .RF_AD     (RF_AD),
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
        .ovf       (ovf),
        .udf       (udf),
`endif
        .ConfigBits(cfg)
    );

    always #5 UserCLK = ~UserCLK;

    // Register-file model: write at the edge, port A combinational or registered.
    logic [3:0] mem [32];
    logic [3:0] ad_q = 4'd0;
    initial for (int i = 0; i < 32; i++) mem[i] = 4'd0;
    always @(posedge UserCLK) begin
        if (RF_W_EN) mem[RF_W_ADR] <= RF_D;
        ad_q <= mem[RF_A_ADR];
    end
    assign RF_AD = cfg[0] ? ad_q : mem[RF_A_ADR];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    logic [3:0] mdl[$];
    logic [3:0] exp_q[$];
    int         exp_cyc[$];
    int         m_wr = 0;
    int         m_rd = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge UserCLK) begin
        if (exp_q.size() > 0 && exp_cyc[0] == cyc) begin
            check_eq("pop_valid", {31'd0, pop_valid}, 32'd1);
            check_eq("pop_data", {28'd0, pop_data}, {28'd0, exp_q[0]});
            void'(exp_q.pop_front());
            void'(exp_cyc.pop_front());
        end else if (pop_valid) begin
            check_eq("spurious_pop_valid", {31'd0, pop_valid}, 32'd0);
        end
    end

    function automatic int depth_of();
        return cfg[1] ? 16 : 32;
    endfunction

    // One cycle: drive, check pre-edge outputs against the model, advance the model.
    task automatic step(input logic p, input logic [3:0] d, input logic q);
        int  e;
        bit  f, em, pacc, qacc;
        push = p; push_data = d; pop = q;
        #1;
        f    = (mdl.size() == depth_of());
        em   = (mdl.size() == 0);
        pacc = p & (!f | q);
        qacc = q & !em;
        check_eq("count", {26'd0, count}, mdl.size());
        check_eq("full", {31'd0, full}, {31'd0, f});
        check_eq("empty", {31'd0, empty}, {31'd0, em});
        check_eq("rf_w_en", {31'd0, RF_W_EN}, {31'd0, pacc});
        check_eq("rf_d", {28'd0, RF_D}, {28'd0, d});
        check_eq("rf_w_adr", {27'd0, RF_W_ADR}, m_wr);
        check_eq("rf_a_adr", {27'd0, RF_A_ADR}, m_rd);
        e = cyc + 1;
        if (qacc) begin
            exp_q.push_back(mdl.pop_front());
            exp_cyc.push_back(e + (cfg[0] ? 1 : 0));
            m_rd = (m_rd + 1) % depth_of();
        end
        if (pacc) begin
            mdl.push_back(d);
            m_wr = (m_wr + 1) % depth_of();
        end
        @(posedge UserCLK);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 4'd0, 1'b0);
        check_eq("drain_complete", exp_q.size(), 0);
    endtask

    // Reset with push/pop held high so Reset priority is exercised too.
    task automatic do_reset(input logic [1:0] c);
        Reset = 1'b1; push = 1'b1; pop = 1'b1; push_data = 4'hE;
        cfg = c;
        #1;
        check_eq("rf_w_en_in_reset", {31'd0, RF_W_EN}, 32'd0);
        @(posedge UserCLK);
        #1;
        Reset = 1'b0; push = 1'b0; pop = 1'b0;
        mdl.delete(); exp_q.delete(); exp_cyc.delete();
        m_wr = 0; m_rd = 0;
        check_eq("rst_count", {26'd0, count}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        check_eq("rst_pop_data", {28'd0, pop_data}, 32'd0);
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("rst_udf", {31'd0, udf}, 32'd0);
`endif
    endtask

    initial begin
        @(posedge UserCLK);
        #1;
        do_reset(2'b00);

        // Fill 32 deep, then one push too many.
        for (int i = 0; i < 32; i++) step(1'b1, 4'(i), 1'b0);
        check_eq("full_after_32", {31'd0, full}, 32'd1);
        check_eq("count_after_32", {26'd0, count}, 32'd32);
        step(1'b1, 4'h9, 1'b0);
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
        check_eq("ovf_set", {31'd0, ovf}, 32'd1);
`endif
        for (int i = 0; i < 32; i++) step(1'b0, 4'd0, 1'b1);
        drain();
        check_eq("empty_after_pops", {31'd0, empty}, 32'd1);
        step(1'b0, 4'd0, 1'b1);
`ifdef REGFILE_FIFO_ERR_FLAGS_EN
        check_eq("udf_set", {31'd0, udf}, 32'd1);
`endif

        // Registered read port: two-cycle pop latency.
        drain();
        do_reset(2'b01);
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'hB, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        drain();
        step(1'b1, 4'h7, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        drain();

        // 16-deep mode with wrap of the write pointer.
        do_reset(2'b10);
        for (int i = 0; i < 17; i++) step(1'b1, 4'(i + 3), 1'b0);
        check_eq("full16", {31'd0, full}, 32'd1);
        check_eq("count16", {26'd0, count}, 32'd16);
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'hC, 1'b0);
        check_eq("wr_adr_wrapped", {27'd0, RF_W_ADR}, 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 1'b1);
        drain();

        // Full FIFO with simultaneous push and pop.
        do_reset(2'b00);
        for (int i = 0; i < 32; i++) step(1'b1, 4'((i * 3) & 15), 1'b0);
        step(1'b1, 4'h5, 1'b1);
        check_eq("count_full_pushpop", {26'd0, count}, 32'd32);
        for (int i = 0; i < 32; i++) step(1'b0, 4'd0, 1'b1);
        drain();

        // Reset with two pops in flight: no strobes may follow.
        do_reset(2'b01);
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        do_reset(2'b01);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b0);
        check_eq("count_after_midreset", {26'd0, count}, 32'd0);
        check_eq("empty_after_midreset", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
